l1_line_arbiter: RTL

- Arbitrates whole-line transfers between the L1 instruction cache (read-only) and the L1 data cache (read/write) onto the single line port of the L2 cache.
- Sits inside the cache hierarchy, directly below both L1 caches and directly above the L2 cache.
- Uses a registered grant FSM with round-robin tie-break, so neither L1 can starve the other.
- Holds the grant until the L2 responds, then releases it.

---
 rtl/l1_line_arbiter_pkg.sv | 27 ++
 rtl/l1_line_arbiter.sv | 118 +++++++++++
 2 files changed

// File: rtl/l1_line_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : l1_line_arbiter_pkg
// Brief   : LC-3b line/word types and L1 line-arbiter state encodings.
// Revision: 1.0
// ============================================================================
package l1_line_arbiter_pkg;

   localparam int unsigned LC3B_WORD_W    = 16;
   localparam int unsigned LC3B_L1_LINE_W = 128;

   typedef logic [LC3B_WORD_W-1:0]    lc3b_word;
   typedef logic [LC3B_L1_LINE_W-1:0] lc3b_l1_line;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } l1_arb_state_t;

   typedef enum logic {
      ARB_SRC_I = 1'b0,
      ARB_SRC_D = 1'b1
   } l1_arb_src_t;

endpackage : l1_line_arbiter_pkg
`default_nettype wire

// File: rtl/l1_line_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : l1_line_arbiter
// Brief   : Round-robin arbiter for whole-line I/D cache transfers onto L2.
// Revision: 1.0
// ============================================================================
module l1_line_arbiter
   import l1_line_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = LC3B_WORD_W,
   parameter int unsigned LINE_W = LC3B_L1_LINE_W
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,

   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_address,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic              l2_resp,
   input  logic [LINE_W-1:0] l2_rdata
);

   l1_arb_state_t r_state;
   l1_arb_state_t w_state_next;
   l1_arb_src_t   r_last_grant;
   l1_arb_src_t   w_last_grant_next;

   logic w_i_req;
   logic w_d_req;

   assign w_i_req = i_read;
   assign w_d_req = d_read | d_write;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= ARB_SRC_D;
      end else begin
         r_state      <= w_state_next;
         r_last_grant <= w_last_grant_next;
      end
   end

   // Grants only leave IDLE, so every grant is separated by an IDLE cycle.
   always_comb begin
      w_state_next      = r_state;
      w_last_grant_next = r_last_grant;
      case (r_state)
         IDLE: begin
            if (w_i_req && w_d_req) begin
               if (r_last_grant == ARB_SRC_D) begin
                  w_state_next      = SERVE_I;
                  w_last_grant_next = ARB_SRC_I;
               end else begin
                  w_state_next      = SERVE_D;
                  w_last_grant_next = ARB_SRC_D;
               end
            end else if (w_i_req) begin
               w_state_next      = SERVE_I;
               w_last_grant_next = ARB_SRC_I;
            end else if (w_d_req) begin
               w_state_next      = SERVE_D;
               w_last_grant_next = ARB_SRC_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (l2_resp) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;

   always_comb begin
      l2_read    = 1'b0;
      l2_write   = 1'b0;
      l2_address = '0;
      l2_wdata   = '0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      case (r_state)
         SERVE_I: begin
            l2_read    = i_read;
            l2_address = i_address;
            i_resp     = l2_resp;
         end
         SERVE_D: begin
            // A simultaneous read and write resolves to the write.
            l2_read    = d_read & ~d_write;
            l2_write   = d_write;
            l2_address = d_address;
            l2_wdata   = d_wdata;
            d_resp     = l2_resp;
         end
         default: begin
         end
      endcase
   end

endmodule : l1_line_arbiter
`default_nettype wire
